// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the memory arbiter and the memory stage.
// FSM states, bus owner codes and byte/word access size constants.
package mem_arbiter_pkg;

    localparam logic ACC_WORD = 1'b0;
    localparam logic ACC_BYTE = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUS_I = 2'd1,
        BUS_D = 2'd2
    } arbState_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } owner_t;

endpackage

// File: rtl/mem_lane_steer.sv
// Byte-lane steering for the data port of the memory arbiter.
// Maps addr[0]/size to hb/lb enables, replicates byte write data, extracts read bytes.
module mem_lane_steer
    import mem_arbiter_pkg::*;
(
    input  logic        addr0,
    input  logic        accSize,
    input  logic [15:0] wdataIn,
    input  logic [15:0] rdataIn,
    output logic        hb,
    output logic        lb,
    output logic [15:0] wdataOut,
    output logic [15:0] rdataOut
);

    // Word accesses pass through; byte accesses pick one lane
    always_comb begin
        hb       = 1'b1;
        lb       = 1'b1;
        wdataOut = wdataIn;
        rdataOut = rdataIn;
        if (accSize == ACC_BYTE) begin
            hb       = addr0;
            lb       = ~addr0;
            wdataOut = {wdataIn[7:0], wdataIn[7:0]};
            rdataOut = addr0 ? {8'h00, rdataIn[15:8]}
                             : {8'h00, rdataIn[7:0]};
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the 16-bit memory bus between instruction fetch and the data stage.
// D has priority, a streak guard prevents fetch starvation, a watchdog aborts hung cycles.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 16,
    parameter int TIMEOUT      = 15,
    parameter int D_STREAK_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_flush,
    output logic              i_done,
    output logic [15:0]       i_data,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic              d_we,
    input  logic              d_byte,
    input  logic [15:0]       d_wdata,
    output logic              d_done,
    output logic [15:0]       d_rdata,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-2:0] bus_addr,
    output logic              bus_hb,
    output logic              bus_lb,
    output logic [15:0]       bus_wdata,
    input  logic [15:0]       bus_rdata,
    input  logic              bus_ack,
    output logic              err
);

    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam int SK_W = $clog2(D_STREAK_MAX + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
    localparam logic [SK_W-1:0] SK_MAX  = SK_W'(D_STREAK_MAX);

    arbState_t         state, nState;
    owner_t            grant;
    logic [SK_W-1:0]   streak, nStreak;
    logic [WD_W-1:0]   wdog, nWdog;
    logic              discard, nDiscard;
    logic              flushNow, busEnd;
    logic              nIDone, nDDone, nErr;
    logic [15:0]       nIData, nDRdata;
    logic              nBusReq, nBusWe, nBusHb, nBusLb;
    logic [ADDR_W-2:0] nBusAddr;
    logic [15:0]       nBusWdata;
    logic              steerHb, steerLb;
    logic [15:0]       steerWdata, steerRdata;

    mem_lane_steer uSteer (
        .addr0    (d_addr[0]),
        .accSize  (d_byte),
        .wdataIn  (d_wdata),
        .rdataIn  (bus_rdata),
        .hb       (steerHb),
        .lb       (steerLb),
        .wdataOut (steerWdata),
        .rdataOut (steerRdata)
    );

    // Register every piece of state and every output
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            streak    <= '0;
            wdog      <= '0;
            discard   <= 1'b0;
            i_done    <= 1'b0;
            i_data    <= '0;
            d_done    <= 1'b0;
            d_rdata   <= '0;
            err       <= 1'b0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_hb    <= 1'b0;
            bus_lb    <= 1'b0;
            bus_wdata <= '0;
        end else begin
            state     <= nState;
            streak    <= nStreak;
            wdog      <= nWdog;
            discard   <= nDiscard;
            i_done    <= nIDone;
            i_data    <= nIData;
            d_done    <= nDDone;
            d_rdata   <= nDRdata;
            err       <= nErr;
            bus_req   <= nBusReq;
            bus_we    <= nBusWe;
            bus_addr  <= nBusAddr;
            bus_hb    <= nBusHb;
            bus_lb    <= nBusLb;
            bus_wdata <= nBusWdata;
        end
    end

    // Arbitration, bus sequencing, watchdog and done/err generation
    always_comb begin
        nState    = state;
        nStreak   = streak;
        nWdog     = wdog;
        nDiscard  = discard;
        nIDone    = 1'b0;
        nIData    = i_data;
        nDDone    = 1'b0;
        nDRdata   = d_rdata;
        nErr      = 1'b0;
        nBusReq   = bus_req;
        nBusWe    = bus_we;
        nBusAddr  = bus_addr;
        nBusHb    = bus_hb;
        nBusLb    = bus_lb;
        nBusWdata = bus_wdata;
        grant     = OWN_NONE;
        busEnd    = 1'b0;
        flushNow  = discard | i_flush;

        unique case (state)
            IDLE: begin
                // a done cycle is a recovery cycle: nobody is granted
                if (!i_done && !d_done) begin
                    if (d_req && i_req && streak == SK_MAX)
                        grant = OWN_I;
                    else if (d_req)
                        grant = OWN_D;
                    else if (i_req)
                        grant = OWN_I;
                end
                case (grant)
                    OWN_I: begin
                        nStreak = '0;
                        if (i_addr[0]) begin
                            nIDone = 1'b1;
                            nErr   = 1'b1;
                            nIData = '0;
                        end else begin
                            nState    = BUS_I;
                            nBusReq   = 1'b1;
                            nBusWe    = 1'b0;
                            nBusAddr  = i_addr[ADDR_W-1:1];
                            nBusHb    = 1'b1;
                            nBusLb    = 1'b1;
                            nBusWdata = '0;
                            nWdog     = '0;
                            nDiscard  = 1'b0;
                        end
                    end
                    OWN_D: begin
                        if (!i_req)
                            nStreak = '0;
                        else if (streak != SK_MAX)
                            nStreak = streak + 1'b1;
                        if (d_addr[0] && d_byte == ACC_WORD) begin
                            nDDone  = 1'b1;
                            nErr    = 1'b1;
                            nDRdata = '0;
                        end else begin
                            nState    = BUS_D;
                            nBusReq   = 1'b1;
                            nBusWe    = d_we;
                            nBusAddr  = d_addr[ADDR_W-1:1];
                            nBusHb    = steerHb;
                            nBusLb    = steerLb;
                            nBusWdata = d_we ? steerWdata : 16'h0000;
                            nWdog     = '0;
                        end
                    end
                    default: ;
                endcase
            end
            BUS_I: begin
                nDiscard = flushNow;
                if (bus_ack) begin
                    busEnd = 1'b1;
                    if (!flushNow) begin
                        nIDone = 1'b1;
                        nIData = bus_rdata;
                    end
                end else if (wdog == WD_LAST) begin
                    busEnd = 1'b1;
                    nErr   = 1'b1;
                    if (!flushNow) begin
                        nIDone = 1'b1;
                        nIData = '0;
                    end
                end else begin
                    nWdog = wdog + 1'b1;
                end
            end
            BUS_D: begin
                if (bus_ack) begin
                    busEnd = 1'b1;
                    nDDone = 1'b1;
                    if (!bus_we)
                        nDRdata = steerRdata;
                end else if (wdog == WD_LAST) begin
                    busEnd  = 1'b1;
                    nErr    = 1'b1;
                    nDDone  = 1'b1;
                    nDRdata = '0;
                end else begin
                    nWdog = wdog + 1'b1;
                end
            end
            default: nState = IDLE;
        endcase

        if (busEnd) begin
            nState    = IDLE;
            nWdog     = '0;
            nDiscard  = 1'b0;
            nBusReq   = 1'b0;
            nBusWe    = 1'b0;
            nBusAddr  = '0;
            nBusHb    = 1'b0;
            nBusLb    = 1'b0;
            nBusWdata = '0;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter.
// One task per scenario; expected values are hand-computed constants.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, i_flush, i_done;
    logic [15:0] i_addr, i_data;
    logic        d_req, d_we, d_byte, d_done;
    logic [15:0] d_addr, d_wdata, d_rdata;
    logic        bus_req, bus_we, bus_hb, bus_lb, bus_ack, err;
    logic [14:0] bus_addr;
    logic [15:0] bus_wdata, bus_rdata;

    int checks = 0;
    int errors = 0;

    mem_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_flush   (i_flush),
        .i_done    (i_done),
        .i_data    (i_data),
        .d_req     (d_req),
        .d_addr    (d_addr),
        .d_we      (d_we),
        .d_byte    (d_byte),
        .d_wdata   (d_wdata),
        .d_done    (d_done),
        .d_rdata   (d_rdata),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_hb    (bus_hb),
        .bus_lb    (bus_lb),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_ack   (bus_ack),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        i_req = 0; i_addr = 0; i_flush = 0;
        d_req = 0; d_addr = 0; d_we = 0; d_byte = 0; d_wdata = 0;
        bus_ack = 0; bus_rdata = 0;
    endtask

    task automatic doReset();
        clearInputs();
        rst = 1;
        step();
        step();
        rst = 0;
    endtask

    task automatic test_reset();
        logic [72:0] outs;
        clearInputs();
        i_req = 1; i_addr = 16'h0010; d_req = 1; d_addr = 16'h0020;
        rst = 1;
        step();
        step();
        outs = {i_done, i_data, d_done, d_rdata, bus_req, bus_we,
                bus_addr, bus_hb, bus_lb, bus_wdata, err};
        checks++;
        if (outs !== '0) begin
            $display("FAIL reset_outputs: got %h expected 0", outs);
            errors++;
        end
        rst = 0;
        clearInputs();
        step();
    endtask

    task automatic test_fetch();
        doReset();
        i_addr = 16'h0102; i_req = 1;
        step();
        checks++;
        if ({bus_req, bus_hb, bus_lb, bus_we} !== 4'b1110 || bus_addr !== 15'h0081) begin
            $display("FAIL fetch_bus: got req/hb/lb/we=%b%b%b%b addr=%h expected 1110 addr=0081",
                     bus_req, bus_hb, bus_lb, bus_we, bus_addr);
            errors++;
        end
        step();
        checks++;
        if (bus_req !== 1'b1 || i_done !== 1'b0) begin
            $display("FAIL fetch_wait: got bus_req=%b i_done=%b expected 1 0", bus_req, i_done);
            errors++;
        end
        bus_ack = 1; bus_rdata = 16'hBEEF;
        step();
        checks++;
        if (i_done !== 1'b1 || i_data !== 16'hBEEF || bus_req !== 1'b0) begin
            $display("FAIL fetch_done: got i_done=%b i_data=%h bus_req=%b expected 1 beef 0",
                     i_done, i_data, bus_req);
            errors++;
        end
        bus_ack = 0; i_req = 0;
        step();
        checks++;
        if (i_done !== 1'b0) begin
            $display("FAIL fetch_pulse: got i_done=%b expected 0", i_done);
            errors++;
        end
    endtask

    task automatic test_byte_lanes();
        doReset();
        d_addr = 16'h0011; d_wdata = 16'h00AB; d_we = 1; d_byte = 1; d_req = 1;
        step();
        checks++;
        if ({bus_req, bus_we, bus_hb, bus_lb} !== 4'b1110 || bus_wdata !== 16'hABAB
            || bus_addr !== 15'h0008) begin
            $display("FAIL byte_write: got req/we/hb/lb=%b%b%b%b wdata=%h addr=%h expected 1110 abab 0008",
                     bus_req, bus_we, bus_hb, bus_lb, bus_wdata, bus_addr);
            errors++;
        end
        bus_ack = 1;
        step();
        checks++;
        if (d_done !== 1'b1 || err !== 1'b0) begin
            $display("FAIL byte_write_done: got d_done=%b err=%b expected 1 0", d_done, err);
            errors++;
        end
        bus_ack = 0; d_req = 0;
        step();
        d_addr = 16'h0010; d_we = 0; d_byte = 1; d_req = 1;
        step();
        checks++;
        if ({bus_req, bus_we, bus_hb, bus_lb} !== 4'b1001 || bus_addr !== 15'h0008) begin
            $display("FAIL byte_read_bus: got req/we/hb/lb=%b%b%b%b addr=%h expected 1001 0008",
                     bus_req, bus_we, bus_hb, bus_lb, bus_addr);
            errors++;
        end
        bus_ack = 1; bus_rdata = 16'h1234;
        step();
        checks++;
        if (d_done !== 1'b1 || d_rdata !== 16'h0034) begin
            $display("FAIL byte_read_lo: got d_done=%b d_rdata=%h expected 1 0034", d_done, d_rdata);
            errors++;
        end
        bus_ack = 0; d_req = 0;
        step();
        d_addr = 16'h0011; d_req = 1;
        step();
        bus_ack = 1;
        step();
        checks++;
        if (d_done !== 1'b1 || d_rdata !== 16'h0012) begin
            $display("FAIL byte_read_hi: got d_done=%b d_rdata=%h expected 1 0012", d_done, d_rdata);
            errors++;
        end
        bus_ack = 0; d_req = 0;
        step();
    endtask

    task automatic test_back_to_back();
        logic [9:0] gotI;
        logic [9:0] expI;
        int n;
        doReset();
        expI = 10'b1000010000;
        gotI = '0;
        n = 0;
        i_addr = 16'h0200; d_addr = 16'h0400; d_we = 0; d_byte = 0;
        i_req = 1; d_req = 1;
        for (int k = 0; k < 80 && n < 10; k++) begin
            step();
            if (bus_req === 1'b1) begin
                gotI[n] = (bus_addr === 15'h0100);
                n++;
            end
            bus_ack = bus_req;
        end
        bus_ack = 0; i_req = 0; d_req = 0;
        checks++;
        if (n != 10) begin
            $display("FAIL b2b_count: got %0d grants expected 10", n);
            errors++;
        end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (gotI[i] !== expI[i]) begin
                $display("FAIL b2b_grant%0d: got %s expected %s", i,
                         gotI[i] ? "I" : "D", expI[i] ? "I" : "D");
                errors++;
            end
        end
        step();
        step();
    endtask

    task automatic test_flush();
        doReset();
        i_addr = 16'h0010; i_req = 1;
        step();
        bus_ack = 1; bus_rdata = 16'h1357;
        step();
        bus_ack = 0; i_req = 0;
        step();
        i_addr = 16'h0040; i_req = 1;
        step();
        i_flush = 1;
        step();
        i_flush = 0; i_addr = 16'h0080;
        bus_ack = 1; bus_rdata = 16'h5555;
        step();
        checks++;
        if (i_done !== 1'b0 || i_data !== 16'h1357 || bus_req !== 1'b0) begin
            $display("FAIL flush_suppress: got i_done=%b i_data=%h bus_req=%b expected 0 1357 0",
                     i_done, i_data, bus_req);
            errors++;
        end
        bus_ack = 0;
        step();
        checks++;
        if (bus_req !== 1'b1 || bus_addr !== 15'h0040) begin
            $display("FAIL flush_refetch: got bus_req=%b addr=%h expected 1 0040", bus_req, bus_addr);
            errors++;
        end
        bus_ack = 1; bus_rdata = 16'h7777;
        step();
        checks++;
        if (i_done !== 1'b1 || i_data !== 16'h7777) begin
            $display("FAIL flush_next_done: got i_done=%b i_data=%h expected 1 7777", i_done, i_data);
            errors++;
        end
        bus_ack = 0; i_req = 0;
        step();
    endtask

    task automatic test_timeout();
        int cnt;
        doReset();
        d_addr = 16'h0020; d_we = 0; d_byte = 0; d_req = 1;
        step();
        bus_ack = 1; bus_rdata = 16'h9999;
        step();
        bus_ack = 0; d_req = 0;
        step();
        d_req = 1;
        step();
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (bus_req !== 1'b1) break;
            cnt++;
            step();
        end
        checks++;
        if (cnt != 15) begin
            $display("FAIL timeout_len: got %0d cycles expected 15", cnt);
            errors++;
        end
        checks++;
        if (err !== 1'b1 || d_done !== 1'b1 || d_rdata !== 16'h0000) begin
            $display("FAIL timeout_abort: got err=%b d_done=%b d_rdata=%h expected 1 1 0000",
                     err, d_done, d_rdata);
            errors++;
        end
        d_req = 0;
        step();
        checks++;
        if (err !== 1'b0 || bus_req !== 1'b0 || d_done !== 1'b0) begin
            $display("FAIL timeout_idle: got err=%b bus_req=%b d_done=%b expected 0 0 0",
                     err, bus_req, d_done);
            errors++;
        end
    endtask

    task automatic test_misaligned_and_reset();
        logic [56:0] busOuts;
        doReset();
        d_addr = 16'h0003; d_we = 0; d_byte = 0; d_req = 1;
        step();
        checks++;
        if (d_done !== 1'b1 || err !== 1'b1 || bus_req !== 1'b0 || d_rdata !== 16'h0000) begin
            $display("FAIL misaligned_d: got d_done=%b err=%b bus_req=%b d_rdata=%h expected 1 1 0 0000",
                     d_done, err, bus_req, d_rdata);
            errors++;
        end
        d_req = 0;
        step();
        i_addr = 16'h0005; i_req = 1;
        step();
        checks++;
        if (i_done !== 1'b1 || err !== 1'b1 || bus_req !== 1'b0 || i_data !== 16'h0000) begin
            $display("FAIL misaligned_i: got i_done=%b err=%b bus_req=%b i_data=%h expected 1 1 0 0000",
                     i_done, err, bus_req, i_data);
            errors++;
        end
        i_req = 0;
        step();
        d_addr = 16'h0004; d_we = 1; d_wdata = 16'h1111; d_req = 1;
        step();
        checks++;
        if (bus_req !== 1'b1 || bus_we !== 1'b1) begin
            $display("FAIL rst_setup: got bus_req=%b bus_we=%b expected 1 1", bus_req, bus_we);
            errors++;
        end
        rst = 1;
        step();
        busOuts = {bus_req, bus_we, bus_addr, bus_hb, bus_lb, bus_wdata,
                   d_done, err, i_done, d_rdata};
        checks++;
        if (busOuts !== '0) begin
            $display("FAIL rst_mid_bus: got %h expected 0", busOuts);
            errors++;
        end
        rst = 0; d_req = 0; bus_ack = 1;
        step();
        step();
        checks++;
        if (d_done !== 1'b0 || bus_req !== 1'b0) begin
            $display("FAIL rst_no_done: got d_done=%b bus_req=%b expected 0 0", d_done, bus_req);
            errors++;
        end
        bus_ack = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL sim_timeout: got no finish expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        clearInputs();
        rst = 1;
        test_reset();
        test_fetch();
        test_byte_lanes();
        test_back_to_back();
        test_flush();
        test_timeout();
        test_misaligned_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
